mod_n_down_counter: RTL and testbench
=====================================

# mod_n_down_counter

Synchronous modulo-N down counter with parallel load, count enable, terminal-count pulse, wrap tally and a one-shot mode. It is the count-down counterpart to the mod-8 up counter: same clock, reset and count-bus conventions, but it decrements. It drives timeout and interval logic that needs a reloadable countdown. The default build is mod-8 on a 4-bit count bus.

## Interface
- WIDTH, 4, count bus width; must satisfy 2^WIDTH >= MODULUS
- MODULUS, 8, count range 0..MODULUS-1; legal range 2..2^WIDTH
- clk  in  1  rising-edge clock; sole clock
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge
- en  in  1  count enable; decrement by 1 per enabled cycle
- load  in  1  parallel load strobe
- load_val  in  WIDTH  value loaded when load=1
- mode  in  1  0 = free-running (wrap), 1 = one-shot (stop at 0)
- count  out  WIDTH  current count, registered
- tc  out  1  terminal-count pulse, registered, 1 cycle
- done  out  1  one-shot expired, sticky
- wrap_cnt  out  8  number of wraps, saturating at 255
- load_err  out  1  sticky, set by an out-of-range load

## Operation
- States: RUN, DONE. Reset state is RUN.
- Per-edge priority: rst low > load > en > hold.
- rst=0: count=MODULUS-1, tc=0, done=0, wrap_cnt=0, load_err=0, state=RUN.
- load=1, any state:
  - count=load_val if load_val < MODULUS; otherwise count=MODULUS-1 and load_err=1.
  - done=0, state=RUN, tc=0. en is ignored that cycle.
- en=1, load=0, state RUN:
  - count>0: count=count-1, tc=0.
  - count==0, mode=0: count=MODULUS-1, tc=1, wrap_cnt=wrap_cnt+1 (holds at 255).
  - count==0, mode=1: count stays 0, tc=1, done=1, state=DONE. wrap_cnt unchanged.
- State DONE: en is ignored, count holds 0, tc=0. Only load or rst exits.
- en=0, no load: all registers hold; tc=0.
- mode is sampled at each edge and only matters when count==0. Changing it mid-count is legal.
- load_err clears only on reset.
- Arithmetic is unsigned WIDTH-bit. No value >= MODULUS ever appears on count.

## Timing
- All outputs are registered and change only on the clk rising edge. No combinational input-to-output paths.
- Decrement latency: 1 cycle from en sampled high.
- tc is high in the same cycle count first shows the wrapped value (MODULUS-1), or first shows DONE. tc lasts exactly 1 cycle per terminal event.
- With en held high in mode 0: tc period = MODULUS cycles.
- Load latency: 1 cycle; count=load_val on the next edge.
- Reset mid-count, or in DONE, fully reinitialises on the first edge with rst=0. Outputs are undefined before the first clock edge.
- Simultaneous load and en: load wins and no decrement occurs.
- Simultaneous load and terminal condition: load wins; no tc, no wrap_cnt increment, no done.

## Test plan
- Reset then count: rst=0 for 2 cycles, then rst=1 and en=1 for 20 cycles, mode=0 -> count 7,6,...,0,7,...; tc high on each 0->7 edge (2 pulses); wrap_cnt=2.
- Enable gating: en toggled 1,0,1,0 from count=5 -> count 4,4,3,3; tc stays 0.
- Load: load=1, load_val=3 while en=1 -> count=3 next cycle, no decrement that cycle. load_val=9 -> count=7, load_err=1 and stays set until rst=0.
- One-shot: mode=1, load 2, en=1 -> count 1,0,0 with tc=1 and done=1 on the third edge. Further en gives no change. load 5 -> done=0, counting resumes.
- Reset mid-operation: rst=0 at count=4 with en=1, and separately in DONE -> next edge count=7, done=0, wrap_cnt=0, tc=0.
- Saturation: mode=0, en=1 for 256×8+16 cycles -> wrap_cnt reaches 255 and holds; tc still pulses every 8 cycles.

Source files
------------

// File: rtl/mod_n_down_counter_if.sv
// Control and status bundle for the modulo-N down counter.
// The master drives the controls; the slave is the counter itself.
interface mod_n_down_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             mode;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             done;
   logic [7:0]       wrap_cnt;
   logic             load_err;

   modport master (
      output en, load, load_val, mode,
      input  count, tc, done, wrap_cnt, load_err
   );

   modport slave (
      input  en, load, load_val, mode,
      output count, tc, done, wrap_cnt, load_err
   );
endinterface

// File: rtl/mod_n_down_counter.sv
// Reloadable modulo-N down counter with a terminal-count pulse,
// a saturating wrap tally, a sticky load-error flag and a one-shot mode.
module mod_n_down_counter #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   mod_n_down_counter_if.slave   bus
);

   typedef enum logic {RUN, DONE} state_t;

   localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MODULUS);
   localparam logic [7:0]       WRAP_SAT = 8'd255;

   state_t           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_tc;
   logic             r_done;
   logic [7:0]       r_wrap_cnt;
   logic             r_load_err;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_tc_nxt;
   logic             w_done_nxt;
   logic [7:0]       w_wrap_cnt_nxt;
   logic             w_load_err_nxt;
   logic             w_load_ok;

   // Widened compare so MODULUS == 2^WIDTH still fits.
   assign w_load_ok = ({1'b0, bus.load_val} < MOD_EXT);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= RUN;
         r_count    <= MAX_VAL;
         r_tc       <= 1'b0;
         r_done     <= 1'b0;
         r_wrap_cnt <= '0;
         r_load_err <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_count    <= w_count_nxt;
         r_tc       <= w_tc_nxt;
         r_done     <= w_done_nxt;
         r_wrap_cnt <= w_wrap_cnt_nxt;
         r_load_err <= w_load_err_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt    = r_state;
      w_count_nxt    = r_count;
      w_tc_nxt       = 1'b0;
      w_done_nxt     = r_done;
      w_wrap_cnt_nxt = r_wrap_cnt;
      w_load_err_nxt = r_load_err;

      if (bus.load) begin
         w_state_nxt = RUN;
         w_done_nxt  = 1'b0;
         if (w_load_ok) begin
            w_count_nxt = bus.load_val;
         end else begin
            w_count_nxt    = MAX_VAL;
            w_load_err_nxt = 1'b1;
         end
      end else if (bus.en && (r_state == RUN)) begin
         if (r_count != '0) begin
            w_count_nxt = r_count - 1'b1;
         end else if (bus.mode) begin
            w_tc_nxt    = 1'b1;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
         end else begin
            w_count_nxt = MAX_VAL;
            w_tc_nxt    = 1'b1;
            if (r_wrap_cnt != WRAP_SAT) begin
               w_wrap_cnt_nxt = r_wrap_cnt + 8'd1;
            end
         end
      end
   end

   always_comb begin
      bus.count    = r_count;
      bus.tc       = r_tc;
      bus.done     = r_done;
      bus.wrap_cnt = r_wrap_cnt;
      bus.load_err = r_load_err;
   end

endmodule

// File: tb/tb_mod_n_down_counter.sv
// Scoreboard bench for mod_n_down_counter: directed scenarios plus random
// traffic, expectations from a behavioural countdown model.
module tb_mod_n_down_counter;

   localparam int WIDTH   = 4;
   localparam int MODULUS = 8;

   typedef struct {
      int count;
      bit tc;
      bit done;
      int wrap;
      bit err;
   } exp_t;

   logic clk;
   logic rst;
   exp_t sb_q[$];
   int   vectors;
   int   miscompares;

   // Behavioural model state
   int m_count;
   bit m_tc;
   bit m_done;
   int m_wrap;
   bit m_err;

   mod_n_down_counter_if #(.WIDTH(WIDTH)) bus ();

   mod_n_down_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int actual, input int expected);
      vectors++;
      if (actual != expected) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference behaviour for one rising edge, from the counter's rules.
   task automatic model_edge(input bit r, input bit e, input bit ld, input int lv, input bit md);
      if (!r) begin
         m_count = MODULUS - 1; m_tc = 0; m_done = 0; m_wrap = 0; m_err = 0;
      end else if (ld) begin
         if (lv < MODULUS) m_count = lv;
         else begin m_count = MODULUS - 1; m_err = 1; end
         m_done = 0; m_tc = 0;
      end else if (e && !m_done) begin
         if (m_count > 0) begin
            m_count = m_count - 1; m_tc = 0;
         end else if (md) begin
            m_tc = 1; m_done = 1;
         end else begin
            m_count = MODULUS - 1; m_tc = 1;
            m_wrap  = (m_wrap < 255) ? m_wrap + 1 : 255;
         end
      end else begin
         m_tc = 0;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit ld, input int lv, input bit md);
      exp_t x;
      @(negedge clk);
      rst          = r;
      bus.en       = e;
      bus.load     = ld;
      bus.load_val = WIDTH'(lv);
      bus.mode     = md;
      model_edge(r, e, ld, lv, md);
      x.count = m_count; x.tc = m_tc; x.done = m_done; x.wrap = m_wrap; x.err = m_err;
      sb_q.push_back(x);
      @(posedge clk);
   endtask

   // Monitor: the counter presents a fresh result after every edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            vectors++;
            if (bus.count !== WIDTH'(x.count) || bus.tc !== x.tc || bus.done !== x.done ||
                bus.wrap_cnt !== 8'(x.wrap) || bus.load_err !== x.err) begin
               miscompares++;
               $display("FAIL vec%0d @%0t: count=%0d tc=%b done=%b wrap=%0d err=%b, expected count=%0d tc=%b done=%b wrap=%0d err=%b",
                        vectors, $time, bus.count, bus.tc, bus.done, bus.wrap_cnt, bus.load_err,
                        x.count, x.tc, x.done, x.wrap, x.err);
            end
         end
      end
   end

   initial begin
      int tc_seen;
      vectors = 0; miscompares = 0;
      rst = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0; bus.mode = 1'b0;

      // Reset then free-run for 20 edges: two wraps, landing on 3.
      repeat (2) step(0, 0, 0, 0, 0);
      #1;
      check("reset_count", int'(bus.count), 7);
      check("reset_wrap", int'(bus.wrap_cnt), 0);
      tc_seen = 0;
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 0, 0, 0);
         #1;
         if (bus.tc) tc_seen++;
      end
      check("run20_count", int'(bus.count), 3);
      check("run20_wrap", int'(bus.wrap_cnt), 2);
      check("run20_tc_pulses", tc_seen, 2);

      // Enable gating from 5.
      step(1, 0, 1, 5, 0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      #1;
      check("gate_count", int'(bus.count), 3);

      // Load beats enable; out-of-range load saturates and flags.
      step(1, 1, 1, 3, 0);
      #1;
      check("load_wins", int'(bus.count), 3);
      step(1, 1, 1, 9, 0);
      #1;
      check("bad_load_count", int'(bus.count), 7);
      check("bad_load_err", int'(bus.load_err), 1);
      repeat (5) step(1, 1, 0, 0, 0);
      #1;
      check("err_sticky", int'(bus.load_err), 1);

      // One-shot expiry, ignored enables, reload resumes.
      step(1, 0, 1, 2, 1);
      repeat (3) step(1, 1, 0, 0, 1);
      #1;
      check("oneshot_done", int'(bus.done), 1);
      check("oneshot_tc", int'(bus.tc), 1);
      repeat (3) step(1, 1, 0, 0, 1);
      #1;
      check("done_hold_count", int'(bus.count), 0);
      check("done_hold_tc", int'(bus.tc), 0);
      step(1, 1, 1, 5, 1);
      step(1, 1, 0, 0, 1);
      #1;
      check("resume_count", int'(bus.count), 4);
      check("resume_done", int'(bus.done), 0);

      // Load colliding with terminal condition: no tc, no wrap.
      step(1, 0, 1, 0, 0);
      step(1, 1, 1, 6, 0);
      #1;
      check("load_vs_tc", int'(bus.tc), 0);

      // Reset mid-count and in DONE.
      step(1, 0, 1, 5, 0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      #1;
      check("rst_mid_count", int'(bus.count), 7);
      check("rst_mid_err", int'(bus.load_err), 0);
      step(1, 0, 1, 0, 1);
      step(1, 1, 0, 0, 1);
      step(0, 1, 0, 0, 1);
      #1;
      check("rst_done_done", int'(bus.done), 0);
      check("rst_done_count", int'(bus.count), 7);

      // Wrap-tally saturation.
      tc_seen = 0;
      for (int i = 0; i < 256 * 8 + 16; i++) begin
         step(1, 1, 0, 0, 0);
         #1;
         if (bus.tc) tc_seen++;
      end
      check("sat_wrap", int'(bus.wrap_cnt), 255);
      check("sat_tc_pulses", tc_seen, 258);

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 63) != 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 7) == 0),
              int'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0));
      end

      for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
      if (sb_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
